// File: rtl/io_seq_pkg.sv
// Shared types and widths for the IO supply sequencer.
package io_seq_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 12;
    localparam int FCNT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF         = 3'd0,
        ST_WAIT_PG     = 3'd1,
        ST_DEBOUNCE    = 3'd2,
        ST_RELEASE_RET = 3'd3,
        ST_ACTIVE      = 3'd4,
        ST_FAULT       = 3'd5
    } seq_state_e;

    // Saturating increment for the fault counter; holds at all-ones.
    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (v == {FCNT_W{1'b1}}) ? v : v + FCNT_W'(1);
    endfunction

endpackage

// File: rtl/io_pg_sync.sv
// Multi-flop synchronizer for one asynchronous power-good input.
module io_pg_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/io_supply_seq.sv
// IO supply sequencer: waits for both pad-ring supplies to be stable, then
// releases pad retention and finally enables pad outputs. Any supply loss
// after retention release latches a sticky fault until cleared.
module io_supply_seq
    import io_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 64,
    parameter int RET_DELAY    = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              pg_vddio_i,
    input  logic              pg_vddx_i,
    input  logic              clr_fault_i,
    output logic              pad_ret_o,
    output logic              pad_oe_en_o,
    output logic              ready_o,
    output logic              fault_o,
    output logic              fault_irq_o,
    output logic [STATE_W-1:0] state_o,
    output logic [FCNT_W-1:0]  fault_cnt_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_DELAY - 1);

    logic pg_vddio_s;
    logic pg_vddx_s;
    logic pg_ok;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fault_entry;

    logic              pad_ret_q;
    logic              pad_oe_en_q;
    logic              ready_q;
    logic              fault_q;
    logic              fault_irq_q;
    logic [FCNT_W-1:0] fault_cnt_q;

    io_pg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vddio (
        .clk (clk),
        .rst (rst),
        .d   (pg_vddio_i),
        .q   (pg_vddio_s)
    );

    io_pg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vddx (
        .clk (clk),
        .rst (rst),
        .d   (pg_vddx_i),
        .q   (pg_vddx_s)
    );

    assign pg_ok = pg_vddio_s & pg_vddx_s;

    // Next-state and counter logic; supply loss beats enable drop once
    // retention has been released.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (en_i) state_d = ST_WAIT_PG;
            end
            ST_WAIT_PG: begin
                if (!en_i) begin
                    state_d = ST_OFF;
                end else if (pg_ok) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!en_i) begin
                    state_d = ST_OFF;
                end else if (!pg_ok) begin
                    state_d = ST_WAIT_PG;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_RELEASE_RET;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE_RET: begin
                if (!pg_ok) begin
                    state_d = ST_FAULT;
                end else if (!en_i) begin
                    state_d = ST_OFF;
                end else if (cnt_q == RET_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!pg_ok) begin
                    state_d = ST_FAULT;
                end else if (!en_i) begin
                    state_d = ST_OFF;
                end
            end
            ST_FAULT: begin
                if (clr_fault_i) state_d = ST_OFF;
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
        fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);
    end

    // State and counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from the next state so they change on the same edge
    // as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_ret_q   <= 1'b1;
            pad_oe_en_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            fault_irq_q <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            pad_ret_q   <= !((state_d == ST_RELEASE_RET) || (state_d == ST_ACTIVE));
            pad_oe_en_q <= (state_d == ST_ACTIVE);
            ready_q     <= (state_d == ST_ACTIVE);
            fault_q     <= (state_d == ST_FAULT);
            fault_irq_q <= fault_entry;
            if (fault_entry) fault_cnt_q <= sat_inc(fault_cnt_q);
        end
    end

    assign pad_ret_o   = pad_ret_q;
    assign pad_oe_en_o = pad_oe_en_q;
    assign ready_o     = ready_q;
    assign fault_o     = fault_q;
    assign fault_irq_o = fault_irq_q;
    assign state_o     = state_q;
    assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_io_supply_seq.sv
// Directed bench for io_supply_seq with DEBOUNCE_CYC=4, RET_DELAY=2,
// SYNC_STAGES=2. Inputs change 1 time unit after a rising edge; outputs
// are sampled at that same point, reflecting the edge just taken.
module tb_io_supply_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic       pg_vddio_i;
    logic       pg_vddx_i;
    logic       clr_fault_i;
    logic       pad_ret_o;
    logic       pad_oe_en_o;
    logic       ready_o;
    logic       fault_o;
    logic       fault_irq_o;
    logic [2:0] state_o;
    logic [7:0] fault_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    io_supply_seq #(
        .DEBOUNCE_CYC (4),
        .RET_DELAY    (2),
        .SYNC_STAGES  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .pg_vddio_i  (pg_vddio_i),
        .pg_vddx_i   (pg_vddx_i),
        .clr_fault_i (clr_fault_i),
        .pad_ret_o   (pad_ret_o),
        .pad_oe_en_o (pad_oe_en_o),
        .ready_o     (ready_o),
        .fault_o     (fault_o),
        .fault_irq_o (fault_irq_o),
        .state_o     (state_o),
        .fault_cnt_o (fault_cnt_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input string name,
                             input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0d expected %0d", tag, name, obs, exp);
        end
    endtask

    // act covers both pad_oe_en_o and ready_o.
    task automatic chk(input string tag, input int st, input int ret, input int act,
                       input int flt, input int irq, input int cnt);
        check_val(tag, "state",     8'(state_o),     8'(st));
        check_val(tag, "pad_ret",   8'(pad_ret_o),   8'(ret));
        check_val(tag, "pad_oe_en", 8'(pad_oe_en_o), 8'(act));
        check_val(tag, "ready",     8'(ready_o),     8'(act));
        check_val(tag, "fault",     8'(fault_o),     8'(flt));
        check_val(tag, "fault_irq", 8'(fault_irq_o), 8'(irq));
        check_val(tag, "fault_cnt", fault_cnt_o,     8'(cnt));
    endtask

    task automatic wait_state(input int exp, input int limit, input string tag);
        int n = 0;
        while (state_o !== 3'(exp) && n < limit) begin
            tick();
            n++;
        end
        check_val(tag, "wait_state", 8'(state_o), 8'(exp));
    endtask

    initial begin
        rst         = 1'b1;
        en_i        = 1'b1;
        pg_vddio_i  = 1'b1;
        pg_vddx_i   = 1'b1;
        clr_fault_i = 1'b0;
        tick();
        tick();
        chk("reset", 0, 1, 0, 0, 0, 0);
        rst = 1'b0;

        // Power-up: pg_ok reaches the FSM two edges after reset release.
        tick(); chk("pu_e1", 1, 1, 0, 0, 0, 0);
        tick(); chk("pu_e2", 1, 1, 0, 0, 0, 0);
        tick(); chk("pu_deb0", 2, 1, 0, 0, 0, 0);
        tick();
        tick();
        tick(); chk("pu_deb3", 2, 1, 0, 0, 0, 0);
        tick(); chk("pu_rel0", 3, 0, 0, 0, 0, 0);
        tick(); chk("pu_rel1", 3, 0, 0, 0, 0, 0);
        tick(); chk("pu_active", 4, 0, 1, 0, 0, 0);

        // Supply loss in ACTIVE.
        pg_vddio_i = 1'b0;
        tick(); chk("loss_sync1", 4, 0, 1, 0, 0, 0);
        tick(); chk("loss_sync2", 4, 0, 1, 0, 0, 0);
        tick(); chk("loss_fault", 5, 1, 0, 1, 1, 1);
        pg_vddio_i = 1'b1;
        tick(); chk("loss_hold", 5, 1, 0, 1, 0, 1);
        clr_fault_i = 1'b1;
        tick(); chk("loss_clr", 0, 1, 0, 0, 0, 1);
        clr_fault_i = 1'b0;
        tick(); chk("re_wait", 1, 1, 0, 0, 0, 1);

        // Glitch on pg_vddx at debounce count 2.
        tick(); chk("gl_deb0", 2, 1, 0, 0, 0, 1);
        pg_vddx_i = 1'b0;
        tick(); chk("gl_deb1", 2, 1, 0, 0, 0, 1);
        pg_vddx_i = 1'b1;
        tick(); chk("gl_deb2", 2, 1, 0, 0, 0, 1);
        tick(); chk("gl_back_wait", 1, 1, 0, 0, 0, 1);
        tick(); chk("gl_restart", 2, 1, 0, 0, 0, 1);
        tick();
        tick();
        tick(); chk("gl_deb3", 2, 1, 0, 0, 0, 1);
        tick(); chk("gl_rel0", 3, 0, 0, 0, 0, 1);
        tick();
        tick(); chk("gl_active", 4, 0, 1, 0, 0, 1);

        // Fault clear is ignored outside FAULT.
        clr_fault_i = 1'b1;
        tick(); chk("clr_ignored", 4, 0, 1, 0, 0, 1);
        clr_fault_i = 1'b0;

        // Enable drop and supply loss reach the FSM in the same cycle.
        pg_vddio_i = 1'b0;
        tick(); chk("sim_sync1", 4, 0, 1, 0, 0, 1);
        tick(); chk("sim_sync2", 4, 0, 1, 0, 0, 1);
        en_i = 1'b0;
        tick(); chk("sim_fault", 5, 1, 0, 1, 1, 2);
        tick(); chk("sim_en_noeffect", 5, 1, 0, 1, 0, 2);
        pg_vddio_i  = 1'b1;
        clr_fault_i = 1'b1;
        tick(); chk("sim_clr", 0, 1, 0, 0, 0, 2);
        clr_fault_i = 1'b0;
        tick(); chk("off_hold", 0, 1, 0, 0, 0, 2);

        // Reset during RELEASE_RET.
        en_i = 1'b1;
        tick(); chk("rr_wait", 1, 1, 0, 0, 0, 2);
        tick(); chk("rr_deb0", 2, 1, 0, 0, 0, 2);
        tick();
        tick();
        tick();
        tick(); chk("rr_rel0", 3, 0, 0, 0, 0, 2);
        rst = 1'b1;
        tick(); chk("rr_reset", 0, 1, 0, 0, 0, 0);
        rst = 1'b0;

        // Fault counter saturation over 260 fault/clear rounds.
        for (int i = 1; i <= 260; i++) begin
            wait_state(4, 40, "sat_active");
            pg_vddio_i = 1'b0;
            wait_state(5, 10, "sat_fault");
            check_val("sat", "fault_cnt", fault_cnt_o, 8'((i > 255) ? 255 : i));
            pg_vddio_i  = 1'b1;
            clr_fault_i = 1'b1;
            tick();
            clr_fault_i = 1'b0;
        end
        chk("sat_off", 0, 1, 0, 0, 0, 255);

        // Enable drop in ACTIVE returns to OFF.
        wait_state(4, 40, "end_active");
        chk("end_active", 4, 0, 1, 0, 0, 255);
        en_i = 1'b0;
        tick(); chk("end_off", 0, 1, 0, 0, 0, 255);

        // Only reset clears the fault counter.
        rst = 1'b1;
        tick(); chk("end_reset", 0, 1, 0, 0, 0, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
